// File: rtl/uart_periph_if.sv
// CPU data-bus port of the UART peripheral: read/write strobes, byte address,
// masked write data and the registered read response.
interface uart_periph_if;
   logic        ren;
   logic [15:0] addr;
   logic [31:0] rdata;
   logic        rd_valid;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  wr_mask;

   modport master (
      output ren, addr, wen, wdata, wr_mask,
      input  rdata, rd_valid
   );

   modport slave (
      input  ren, addr, wen, wdata, wr_mask,
      output rdata, rd_valid
   );
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped UART: DATA/STATUS/DIV register window, TX FIFO feeding a serialiser,
// and a single-entry receive register fed by a synchronised deserialiser.
module uart_periph #(
   parameter logic [15:0] BASE       = 16'hF000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd104
) (
   input  logic         clk,
   input  logic         rst,
   uart_periph_if.slave bus,
   output logic         tx,
   input  logic         rx
);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);

   // ---------------- bus decode ----------------
   logic       sel;
   logic [1:0] offs;
   logic       wr_cyc, rd_cyc;
   logic       data_push, data_rd, stat_rd, div_wr;

   assign sel       = (bus.addr[15:4] == BASE[15:4]);
   assign offs      = bus.addr[3:2];
   assign wr_cyc    = bus.wen & sel;
   assign rd_cyc    = bus.ren & sel & ~bus.wen;
   assign data_push = wr_cyc & (offs == 2'd0) & bus.wr_mask[3];
   assign div_wr    = wr_cyc & (offs == 2'd2);
   assign data_rd   = rd_cyc & (offs == 2'd0);
   assign stat_rd   = rd_cyc & (offs == 2'd1);

   logic unused_bus_bits;
   assign unused_bus_bits = &{1'b0, bus.addr[1:0], bus.wdata[31:16], bus.wr_mask[1:0]};

   // ---------------- registers ----------------
   logic [15:0] div_q, div_eff, bit_reload, half_reload;
   logic        rx_valid, rx_overrun, tx_drop, rx_ferr;
   logic [7:0]  rx_byte;

   assign div_eff     = (div_q < 16'd2) ? 16'd2 : div_q;
   assign bit_reload  = div_eff - 16'd1;
   assign half_reload = (div_eff >> 1) - 16'd1;

   // ---------------- TX FIFO ----------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          fifo_full, fifo_empty, push_ok, push_drop, tx_pop;

   assign fifo_full  = (fifo_cnt == FIFO_FULL);
   assign fifo_empty = (fifo_cnt == '0);
   assign push_ok    = data_push & (~fifo_full | tx_pop);
   assign push_drop  = data_push & fifo_full & ~tx_pop;

   // NOTE: storage has no reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.wdata[7:0];
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, tx_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   uart_state_t tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        tx_d, tx_tick, tx_empty;

   assign tx_tick  = (tx_cnt_q == 16'd0);
   assign tx_empty = fifo_empty & (tx_state_q == ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx         <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tx         <= tx_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case can infer a latch.
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_d       = tx;
      tx_pop     = 1'b0;
      case (tx_state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               tx_pop     = 1'b1;
               tx_state_d = ST_START;
               tx_shift_d = fifo_mem[rd_ptr];
               tx_cnt_d   = bit_reload;
               tx_d       = 1'b0;
            end
         end
         ST_START: begin
            if (tx_tick) begin
               tx_state_d = ST_DATA;
               tx_bit_d   = 3'd0;
               tx_cnt_d   = bit_reload;
               tx_d       = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (tx_tick) begin
               tx_cnt_d = bit_reload;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = ST_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (tx_tick) begin
               // A queued byte starts its start bit straight after the stop bit.
               if (!fifo_empty) begin
                  tx_pop     = 1'b1;
                  tx_state_d = ST_START;
                  tx_shift_d = fifo_mem[rd_ptr];
                  tx_cnt_d   = bit_reload;
                  tx_d       = 1'b0;
               end else begin
                  tx_state_d = ST_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   // ---------------- RX synchroniser and FSM ----------------
   logic        rx_s1, rx_s2, rx_s3;
   uart_state_t rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        rx_tick, rx_done, rx_ferr_set;

   assign rx_tick = (rx_cnt_q == 16'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_s3      <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_shift_q <= '0;
         rx_bit_q   <= '0;
      end else begin
         rx_s1      <= rx;
         rx_s2      <= rx_s1;
         rx_s3      <= rx_s2;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_bit_d    = rx_bit_q;
      rx_done     = 1'b0;
      rx_ferr_set = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            if (rx_s3 && !rx_s2) begin
               rx_state_d = ST_START;
               rx_cnt_d   = half_reload;
            end
         end
         ST_START: begin
            if (rx_tick) begin
               if (rx_s2) begin
                  rx_state_d = ST_IDLE;
               end else begin
                  rx_state_d = ST_DATA;
                  rx_bit_d   = 3'd0;
                  rx_cnt_d   = bit_reload;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (rx_tick) begin
               rx_shift_d = {rx_s2, rx_shift_q[7:1]};
               rx_cnt_d   = bit_reload;
               if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (rx_tick) begin
               rx_done     = rx_s2;
               rx_ferr_set = ~rx_s2;
               rx_state_d  = ST_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   // ---------------- control/status registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= DIV_RESET;
         rx_valid   <= 1'b0;
         rx_byte    <= '0;
         rx_overrun <= 1'b0;
         tx_drop    <= 1'b0;
         rx_ferr    <= 1'b0;
      end else begin
         if (div_wr && bus.wr_mask[3]) div_q[7:0]  <= bus.wdata[7:0];
         if (div_wr && bus.wr_mask[2]) div_q[15:8] <= bus.wdata[15:8];

         // A DATA read in the same cycle frees the register, so the new byte wins.
         if (rx_done && (!rx_valid || data_rd)) begin
            rx_byte  <= rx_shift_q;
            rx_valid <= 1'b1;
         end else if (data_rd) begin
            rx_valid <= 1'b0;
         end

         // Sticky bits: a new event in the clearing cycle is kept.
         rx_overrun <= (rx_overrun & ~stat_rd) | (rx_done & rx_valid & ~data_rd);
         tx_drop    <= (tx_drop & ~stat_rd) | push_drop;
         rx_ferr    <= (rx_ferr & ~stat_rd) | rx_ferr_set;
      end
   end

   // ---------------- read response ----------------
   logic [31:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (offs)
         2'd0:    rd_mux = {23'b0, rx_valid, rx_byte};
         2'd1:    rd_mux = {26'b0, rx_ferr, tx_drop, rx_overrun, rx_valid, tx_empty, fifo_full};
         2'd2:    rd_mux = {16'b0, div_q};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rd_valid <= 1'b0;
         bus.rdata    <= '0;
      end else begin
         bus.rd_valid <= rd_cyc;
         bus.rdata    <= rd_cyc ? rd_mux : 32'h0;
      end
   end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: read responses and TX frames are scored
// against queues of expectations filled when the stimulus is driven.
module tb_uart_periph;

   localparam logic [15:0] BASE  = 16'hF000;
   localparam logic [15:0] A_DAT = BASE;
   localparam logic [15:0] A_STA = BASE + 16'h4;
   localparam logic [15:0] A_DIV = BASE + 16'h8;
   localparam logic [15:0] A_RES = BASE + 16'hC;

   typedef struct {
      string       name;
      logic [31:0] data;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic tx;

   uart_periph_if bus();

   uart_periph #(.BASE(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd104)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .tx  (tx),
      .rx  (rx)
   );

   always #5 clk = ~clk;

   int      n_cmp = 0;
   int      n_mis = 0;
   int      cyc = 0;
   int      tb_div = 104;
   bit      mon_en = 1'b0;
   rd_exp_t rd_q[$];
   logic [7:0] tx_q[$];
   int      start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Read-response scoreboard, sampled mid-cycle.
   always begin : rd_mon
      rd_exp_t e;
      @(negedge clk);
      n_cmp++;
      if (bus.rd_valid === 1'b1) begin
         if (rd_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_rd_valid: rdata=%h with no read outstanding", bus.rdata);
         end else begin
            e = rd_q.pop_front();
            if (bus.rdata !== e.data) begin
               n_mis++;
               $display("FAIL %s: rdata=%h expected %h", e.name, bus.rdata, e.data);
            end
         end
      end else if (bus.rdata !== 32'h0) begin
         n_mis++;
         $display("FAIL rdata_idle_zero: rdata=%h expected 0", bus.rdata);
      end
   end

   // TX frame monitor: samples each bit at its centre and scores the frame.
   always begin : tx_mon
      logic [9:0]  fr;
      logic [7:0]  eb;
      int          d, cur, tgt, st;
      bit          ab;
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
         d   = tb_div;
         st  = cyc;
         ab  = 1'b0;
         cur = 0;
         for (int k = 0; k < 10; k++) begin
            tgt = k * d + d / 2;
            repeat (tgt - cur) @(negedge clk);
            cur   = tgt;
            fr[k] = tx;
            if (rst) ab = 1'b1;
         end
         repeat (10 * d - 1 - cur) @(negedge clk);
         if (!ab) begin
            start_q.push_back(st);
            n_cmp++;
            if (tx_q.size() == 0) begin
               n_mis++;
               $display("FAIL unexpected_tx_frame: bits=%b with nothing queued", fr);
            end else begin
               eb = tx_q.pop_front();
               if (fr !== {1'b1, eb, 1'b0}) begin
                  n_mis++;
                  $display("FAIL tx_frame: bits(stop..start)=%b expected %b", fr, {1'b1, eb, 1'b0});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #800_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bus tasks (entered and left at posedge+1) ----------------
   task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
      bus.wen = 1'b1; bus.addr = a; bus.wdata = d; bus.wr_mask = m;
      @(posedge clk); #1;
      bus.wen = 1'b0; bus.wr_mask = 4'h0;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string nm);
      rd_exp_t e;
      e.name = nm;
      e.data = exp;
      rd_q.push_back(e);
      bus.ren = 1'b1; bus.addr = a;
      @(posedge clk); #1;
      bus.ren = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tx_drain(input int budget, output bit ok);
      int n = 0;
      while (tx_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      ok = (tx_q.size() == 0);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      wait_cycles(tb_div);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cycles(tb_div);
      end
      rx = stop;
      wait_cycles(tb_div);
      rx = 1'b1;
      wait_cycles(tb_div);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      wait_cycles(1);
      n_cmp++;
      if (tx !== 1'b1) begin n_mis++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
      bus_read(A_STA, 32'h2, "reset_status");
      bus_read(A_DIV, 32'd104, "reset_div");
      bus_read(A_DAT, 32'h0, "reset_data");
      wait_cycles(1);
      n_cmp++;
      if (rd_q.size() != 0) begin n_mis++; $display("FAIL reset_reads_answered: outstanding=%0d expected 0", rd_q.size()); end
   endtask

   task automatic test_tx_single;
      bit ok;
      bus_write(A_DIV, 32'h0000_0004, 4'b1100);
      tb_div = 4;
      bus_read(A_DIV, 32'd4, "div_write");
      mon_en = 1'b1;
      tx_q.push_back(8'hA5);
      bus_write(A_DAT, 32'h0000_00A5, 4'b1000);
      n_cmp++;
      if (tx !== 1'b1) begin n_mis++; $display("FAIL tx_latency_edge: tx=%b expected 1 at write edge", tx); end
      wait_cycles(1);
      n_cmp++;
      if (tx !== 1'b0) begin n_mis++; $display("FAIL tx_latency_start: tx=%b expected 0 one clock after write", tx); end
      bus_read(A_STA, 32'h0, "status_tx_busy");
      wait_tx_drain(100, ok);
      n_cmp++;
      if (!ok) begin n_mis++; $display("FAIL tx_single_timeout: frames pending=%0d expected 0", tx_q.size()); end
      wait_cycles(2 * tb_div);
      bus_read(A_STA, 32'h2, "status_tx_done");
      // Data lane gated by wr_mask[3]: nothing must be queued.
      bus_write(A_DAT, 32'h0000_00EE, 4'b0111);
      bus_read(A_STA, 32'h2, "status_mask_no_push");
   endtask

   task automatic test_div_small;
      bit ok;
      bus_write(A_DIV, 32'h0000_0001, 4'b1100);
      tb_div = 2;
      bus_read(A_DIV, 32'd1, "div_one_read");
      tx_q.push_back(8'h96);
      bus_write(A_DAT, 32'h0000_0096, 4'b1000);
      wait_tx_drain(60, ok);
      n_cmp++;
      if (!ok) begin n_mis++; $display("FAIL div1_timeout: frames pending=%0d expected 0", tx_q.size()); end
      wait_cycles(6);
      bus_write(A_DIV, 32'h0000_0000, 4'b1100);
      tx_q.push_back(8'h4B);
      bus_write(A_DAT, 32'h0000_004B, 4'b1000);
      wait_tx_drain(60, ok);
      n_cmp++;
      if (!ok) begin n_mis++; $display("FAIL div0_timeout: frames pending=%0d expected 0", tx_q.size()); end
      wait_cycles(6);
      bus_write(A_DIV, 32'h0000_0004, 4'b1100);
      tb_div = 4;
      wait_cycles(2);
   endtask

   task automatic test_back_to_back;
      bit ok;
      start_q.delete();
      for (int i = 0; i < 10; i++) begin
         // First byte is popped at once, 8 more fill the FIFO, the tenth is dropped.
         if (i < 9) tx_q.push_back(8'h30 + 8'(i));
         bus_write(A_DAT, 32'h30 + i, 4'b1000);
      end
      bus_read(A_STA, 32'h11, "status_full_drop");
      bus_read(A_STA, 32'h01, "status_drop_cleared");
      wait_tx_drain(9 * 40 + 60, ok);
      n_cmp++;
      if (!ok) begin n_mis++; $display("FAIL b2b_timeout: frames pending=%0d expected 0", tx_q.size()); end
      n_cmp++;
      if (start_q.size() != 9) begin
         n_mis++;
         $display("FAIL b2b_frame_count: frames=%0d expected 9", start_q.size());
      end else begin
         n_cmp++;
         if (start_q[8] - start_q[0] != 8 * 40) begin
            n_mis++;
            $display("FAIL b2b_contiguous: span=%0d cycles expected %0d", start_q[8] - start_q[0], 8 * 40);
         end
      end
      wait_cycles(8);
      bus_read(A_STA, 32'h2, "status_after_b2b");
   endtask

   task automatic test_rx;
      send_rx(8'h3C, 1'b1);
      bus_read(A_STA, 32'h6, "status_rx_valid");
      bus_read(A_DAT, 32'h13C, "rx_data_first");
      bus_read(A_DAT, 32'h03C, "rx_data_second");
      bus_read(A_STA, 32'h2, "status_rx_cleared");
      // One-clock glitch: false start, nothing received.
      rx = 1'b0;
      wait_cycles(1);
      rx = 1'b1;
      wait_cycles(4 * tb_div);
      bus_read(A_STA, 32'h2, "status_false_start");
   endtask

   task automatic test_rx_errors;
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      send_rx(8'h55, 1'b0);
      bus_read(A_STA, 32'h2E, "status_overrun_ferr");
      bus_read(A_DAT, 32'h111, "rx_data_kept_first");
      bus_read(A_STA, 32'h2, "status_errors_cleared");
   endtask

   task automatic test_reset_mid_frame;
      mon_en = 1'b0;
      bus_write(A_DAT, 32'h0, 4'b1000);
      bus_write(A_DAT, 32'h0, 4'b1000);
      wait_cycles(6);
      n_cmp++;
      if (tx !== 1'b0) begin n_mis++; $display("FAIL midframe_data_bit: tx=%b expected 0", tx); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (tx !== 1'b1) begin n_mis++; $display("FAIL reset_async_tx: tx=%b expected 1", tx); end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      wait_cycles(1);
      n_cmp++;
      if (tx !== 1'b1) begin n_mis++; $display("FAIL post_reset_tx: tx=%b expected 1", tx); end
      bus_read(A_STA, 32'h2, "status_after_reset");
      bus_read(A_DIV, 32'd104, "div_after_reset");
      bus_read(A_RES, 32'h0, "reserved_read");
      // Unselected read: no response.
      bus.ren = 1'b1; bus.addr = BASE + 16'h10;
      wait_cycles(1);
      bus.ren = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.rd_valid !== 1'b0) begin n_mis++; $display("FAIL unselected_read: rd_valid=%b expected 0", bus.rd_valid); end
      wait_cycles(1);
      // Read and write together: write happens, no response.
      bus.ren = 1'b1;
      bus_write(A_DIV, 32'h0000_0007, 4'b1100);
      bus.ren = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.rd_valid !== 1'b0) begin n_mis++; $display("FAIL ren_wen_no_response: rd_valid=%b expected 0", bus.rd_valid); end
      wait_cycles(1);
      bus_write(BASE + 16'h18, 32'h0000_0055, 4'b1100);
      bus_write(BASE + 16'h10, 32'h0000_0099, 4'b1000);
      bus_read(A_DIV, 32'd7, "div_unselected_ignored");
      bus_read(A_STA, 32'h2, "status_unselected_ignored");
      wait_cycles(2);
      n_cmp++;
      if (rd_q.size() != 0) begin n_mis++; $display("FAIL reads_answered: outstanding=%0d expected 0", rd_q.size()); end
   endtask

   initial begin : main
      rst = 1'b1;
      rx = 1'b1;
      bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wr_mask = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_tx_single();
      test_div_small();
      test_back_to_back();
      test_rx();
      test_rx_errors();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
